// File: rtl/nibble_seq_pkg.sv
// Shared constants, FSM state type and counter sizing for the nibble-serial adder.
package nibble_seq_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width / NIBBLE_W);
  endfunction

endpackage

// File: rtl/nibble_adder.sv
// Combinational 4-bit ripple-carry adder slice built from per-bit full adders.
module nibble_adder
  import nibble_seq_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a_i,
  input  logic [NIBBLE_W-1:0] b_i,
  input  logic                cin_i,
  output logic [NIBBLE_W-1:0] sum_o,
  output logic                cout_o
);

  logic [NIBBLE_W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < NIBBLE_W; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o = c[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sequencer.sv
// WIDTH-bit adder that streams operands one nibble per cycle through a single 4-bit slice.
// Define NIBBLE_SEQ_SUB_EN to add the sub port (a - b - cin with borrow-out on cout).
module nibble_add_sequencer
  import nibble_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned N              = WIDTH / NIBBLE_W;
  localparam int unsigned CntW           = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt    = CntW'(N - 1);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q;
  logic [CntW-1:0]   cnt_q;
  logic              sub_q;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [NIBBLE_W-1:0] slice_sum;
  logic              slice_cout;

`ifdef NIBBLE_SEQ_SUB_EN
  // Subtraction is a + ~b + ~borrow; the final carry is inverted back into a borrow.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? ~cin : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  nibble_adder u_slice (
    .a_i    (a_q[NIBBLE_W-1:0]),
    .b_i    (b_q[NIBBLE_W-1:0]),
    .cin_i  (carry_q),
    .sum_o  (slice_sum),
    .cout_o (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StRun;
      StRun:   if (cnt_q == LastCnt) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
    end else begin
      if (state_q == StIdle && in_valid) begin
        a_q     <= a;
        b_q     <= b_eff;
        sum_q   <= '0;
        carry_q <= cin_eff;
        cnt_q   <= '0;
`ifdef NIBBLE_SEQ_SUB_EN
        sub_q   <= sub;
`else
        sub_q   <= 1'b0;
`endif
      end else if (state_q == StRun) begin
        // Slice result enters at the top so nibble 0 ends up in the low bits after N shifts.
        a_q     <= {{NIBBLE_W{1'b0}}, a_q[WIDTH-1:NIBBLE_W]};
        b_q     <= {{NIBBLE_W{1'b0}}, b_q[WIDTH-1:NIBBLE_W]};
        sum_q   <= {slice_sum, sum_q[WIDTH-1:NIBBLE_W]};
        carry_q <= slice_cout;
        cnt_q   <= cnt_q + CntW'(1);
      end
    end
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    sum       = out_valid ? sum_q : '0;
    cout      = out_valid ? (carry_q ^ sub_q) : 1'b0;
  end

endmodule

// File: doc/nibble_add_sequencer.md
# nibble_add_sequencer

Multi-cycle wide adder. Accepts a WIDTH-bit operand pair plus carry-in over a valid/ready handshake and streams it one 4-bit nibble per clock through a single 4-bit ripple-carry adder slice. A registered carry links successive nibbles. Sits between the operand source and the result consumer, so the datapath can reuse one 4-bit adder for any word width that is a multiple of 4.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  operand pair presented
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in; borrow-in in subtract mode
- sub  input  1  subtract select; port exists only with NIBBLE_SEQ_SUB_EN
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- sum  output  WIDTH  result word
- cout  output  1  carry-out; borrow-out in subtract mode

## Operation
- N = WIDTH/4 nibbles. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid:
  - latch a, b, and carry register ← cin into shift registers
  - clear the nibble counter
  - go to RUN
- RUN: each cycle:
  - feed low nibble of a_sh, b_sh and carry into the adder slice
  - shift the 4-bit slice sum into the top of sum_sh
  - shift a_sh and b_sh right by 4; carry ← slice carry-out
  - counter++; after nibble N-1 go to DONE
  - in_ready=0; in_valid is ignored
- DONE: out_valid=1, sum=sum_sh, cout=carry register. Outputs are held stable until out_ready=1, then go to IDLE.
- Arithmetic: sum = (a + b + cin) mod 2^WIDTH, cout = bit WIDTH of the full sum. Unsigned; no overflow flag.
- in_ready is a combinational decode of state==IDLE. out_valid is a decode of state==DONE.
- sum and cout are registered and read 0 outside DONE.
- Reset (any state, including mid-RUN or DONE):
  - state→IDLE, all registers 0
  - out_valid=0, sum=0, cout=0, in_ready=1 on the first cycle after reset
  - an in-flight operation is discarded with no output

## Timing
- Accept edge T (in_valid & in_ready sampled high).
- Nibble k is computed in cycle T+1+k, for k = 0..N-1.
- out_valid rises at T+N+1. Latency from accept to result is N+1 cycles (5 for WIDTH=16).
- If out_ready is high at T+N+1: in_ready returns at T+N+2. Minimum initiation interval is N+2 cycles.
- Backpressure in DONE can last any number of cycles. No new accept happens until the result is taken.
- There is no simultaneous accept and deliver: DONE→IDLE takes one cycle before the next accept.

## Configuration
- NIBBLE_SEQ_SUB_EN defined:
  - the sub port exists and is latched together with the operands
  - when sub=1: b_eff = ~b, initial carry = ~cin (cin acts as borrow-in)
  - cout = ~final carry (borrow-out), giving sum = a − b − cin mod 2^WIDTH
  - when sub=0: behaviour is identical to the macro-absent build
- Macro absent: there is no sub port and the block performs addition only.

## Structure
- Package nibble_seq_pkg holds:
  - NIBBLE_W = 4
  - the state typedef (IDLE, RUN, DONE)
  - a helper constant function for the counter width, $clog2(WIDTH/4)
- Sub-module nibble_adder: purely combinational 4-bit ripple-carry adder (a, b, cin → sum, cout) built from per-bit full-adder equations. It has exactly one instance in the sequencer.

## Test plan
- Add: WIDTH=16, a=0x1234, b=0x4321, cin=0 → sum=0x5555, cout=0. out_valid is first seen exactly 5 cycles after the accept edge.
- Full carry chain: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1. a=0xA5A5, b=0x5A5A, cin=1 → sum=0x0000, cout=1.
- Backpressure: hold out_ready=0 for 3 cycles in DONE → sum and cout stay stable, in_ready=0, and an in_valid pulse during that time is not accepted. The result is taken when out_ready=1, and in_ready=1 on the next cycle.
- Reset mid-RUN: assert rst at T+2 → out_valid never rises, in_ready=1 at T+3. Next op 0x0001+0x0001 → 0x0002, cout=0.
- Back-to-back: two ops with out_ready held at 1 → second accept occurs exactly N+2 cycles after the first, and both results are correct.
- NIBBLE_SEQ_SUB_EN: sub=1, a=0x0005, b=0x0007, cin=0 → sum=0xFFFE, cout=1. a=0x0007, b=0x0005 → sum=0x0002, cout=0.
